// File: rtl/sram_pkg.sv
// Shared constants for the external asynchronous-SRAM bus controller.
package sram_pkg;
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam int WAIT_W = 4;
endpackage

// File: rtl/sram_bus_ctrl.sv
// Cycle-sequenced async-SRAM controller: CPU cs/we/ack handshake in, SRAM pins out.
// Every pin is a flop loaded from the next-state decode, so the pads never glitch.
module sram_bus_ctrl
  import sram_pkg::*;
#(
  parameter int CPU_AW  = 16,
  parameter int SRAM_AW = 18,
  parameter int DW      = 8,
  parameter int RD_WAIT = 1,
  parameter int WR_WAIT = 1
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_cs,
  input  logic                  i_we,
  input  logic [CPU_AW-1:0]     i_addr,
  input  logic [DW-1:0]         i_dat,
  output logic [DW-1:0]         o_dat,
  output logic                  o_ack,
  output logic                  o_busy,
  input  logic [SRAM_AW-CPU_AW-1:0] i_bank,
  output logic [SRAM_AW-1:0]    o_sram_addr,
  output logic [DW-1:0]         o_sram_dat,
  output logic                  o_sram_dat_oe,
  input  logic [DW-1:0]         i_sram_dat,
  output logic                  o_sram_cs_n,
  output logic                  o_sram_oe_n,
  output logic                  o_sram_we_n
);

  localparam int WAIT_MAX = (1 << WAIT_W) - 1;

  if (RD_WAIT < 0 || RD_WAIT > WAIT_MAX || WR_WAIT < 0 || WR_WAIT > WAIT_MAX) begin : g_bad_wait
    $error("sram_bus_ctrl: RD_WAIT/WR_WAIT must be within 0..%0d", WAIT_MAX);
  end
  if (SRAM_AW < CPU_AW) begin : g_bad_aw
    $error("sram_bus_ctrl: SRAM_AW must be >= CPU_AW");
  end

  logic [1:0]        state, nxt;
  logic [WAIT_W-1:0] wcnt;
  logic              we_r;
  logic              we_nx;

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (i_cs) nxt = SETUP;
      SETUP:   nxt = ACCESS;
      ACCESS:  if (wcnt == '0) nxt = DONE;
      default: nxt = IDLE;
    endcase
    // direction of the cycle being entered; only IDLE can start a new one
    we_nx = (state == IDLE) ? i_we : we_r;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state         <= IDLE;
      wcnt          <= '0;
      we_r          <= 1'b0;
      o_dat         <= '0;
      o_ack         <= 1'b0;
      o_busy        <= 1'b0;
      o_sram_addr   <= '0;
      o_sram_dat    <= '0;
      o_sram_dat_oe <= 1'b0;
      o_sram_cs_n   <= 1'b1;
      o_sram_oe_n   <= 1'b1;
      o_sram_we_n   <= 1'b1;
    end else begin
      state <= nxt;
      case (state)
        IDLE: if (i_cs) begin
          o_sram_addr <= {i_bank, i_addr};
          o_sram_dat  <= i_dat;
          we_r        <= i_we;
          wcnt        <= i_we ? WAIT_W'(WR_WAIT) : WAIT_W'(RD_WAIT);
        end
        ACCESS: begin
          if (wcnt != '0)  wcnt  <= wcnt - 1'b1;
          else if (!we_r)  o_dat <= i_sram_dat;
        end
        default: ;
      endcase
      // oe_n and we_n/dat_oe key off opposite directions, so they are exclusive
      o_sram_cs_n   <= (nxt == IDLE);
      o_sram_oe_n   <= !((nxt == ACCESS) && !we_nx);
      o_sram_we_n   <= !((nxt == ACCESS) && we_nx);
      o_sram_dat_oe <= (nxt != IDLE) && we_nx;
      o_ack         <= (nxt == DONE);
      o_busy        <= (nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_sram_bus_ctrl.sv
// Directed bench for sram_bus_ctrl: main DUT (RD_WAIT=1, WR_WAIT=0) on an SRAM model,
// plus three DUTs sweeping the wait parameters over {0,3,15}.
module tb_sram_bus_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        cs, we;
  logic [15:0] addr;
  logic [7:0]  dat_w, dat_r;
  logic        ack, busy;
  logic [1:0]  bank;
  logic [17:0] sram_addr;
  logic [7:0]  sram_dout, sram_din;
  logic        sram_doe, sram_cs_n, sram_oe_n, sram_we_n;

  always #5 clk = ~clk;

  sram_bus_ctrl #(.CPU_AW(16), .SRAM_AW(18), .DW(8), .RD_WAIT(1), .WR_WAIT(0)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_cs(cs), .i_we(we), .i_addr(addr), .i_dat(dat_w),
    .o_dat(dat_r), .o_ack(ack), .o_busy(busy), .i_bank(bank), .o_sram_addr(sram_addr),
    .o_sram_dat(sram_dout), .o_sram_dat_oe(sram_doe), .i_sram_dat(sram_din),
    .o_sram_cs_n(sram_cs_n), .o_sram_oe_n(sram_oe_n), .o_sram_we_n(sram_we_n));

  localparam int SW_RD [3] = '{0, 3, 15};
  localparam int SW_WR [3] = '{3, 15, 0};
  logic [2:0]        sw_ack, sw_busy, sw_doe, sw_cs_n, sw_oe_n, sw_we_n;
  logic [2:0][7:0]   sw_dat, sw_dout;
  logic [2:0][17:0]  sw_addr;
  logic [7:0]        sw_din = 8'h00;

  for (genvar g = 0; g < 3; g++) begin : g_sw
    sram_bus_ctrl #(.CPU_AW(16), .SRAM_AW(18), .DW(8), .RD_WAIT(SW_RD[g]), .WR_WAIT(SW_WR[g])) u_sw (
      .i_clk(clk), .i_reset_n(rst_n), .i_cs(cs), .i_we(we), .i_addr(addr), .i_dat(dat_w),
      .o_dat(sw_dat[g]), .o_ack(sw_ack[g]), .o_busy(sw_busy[g]), .i_bank(bank),
      .o_sram_addr(sw_addr[g]), .o_sram_dat(sw_dout[g]), .o_sram_dat_oe(sw_doe[g]),
      .i_sram_dat(sw_din), .o_sram_cs_n(sw_cs_n[g]), .o_sram_oe_n(sw_oe_n[g]),
      .o_sram_we_n(sw_we_n[g]));
  end

  // SRAM model: 256 bytes decoded on the low address bits
  logic [7:0] mem [256];
  logic       mem_init;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      mem[8'h34] <= 8'hA5;
    end else if (!sram_cs_n && !sram_we_n) begin
      mem[sram_addr[7:0]] <= sram_dout;
    end
  end
  assign sram_din = (!sram_cs_n && !sram_oe_n) ? mem[sram_addr[7:0]] : 8'h00;

  int viol = 0;
  always @(negedge clk) begin
    if ((!sram_we_n && !sram_oe_n) || (sram_doe && !sram_oe_n) ||
        (|(~sw_we_n & ~sw_oe_n)) || (|(sw_doe & ~sw_oe_n)))
      viol++;
  end

  int n_chk = 0, n_err = 0;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // per-cycle trace, bit c = cycle c after the request was presented
  logic [23:0] tr_ack, tr_cs, tr_oe, tr_we, tr_doe;
  logic [7:0]  tr_pad [24];
  logic [17:0] tr_addr;
  int          sw_first [3];

  task automatic trace_step(input int c);
    tr_ack[c] = ack;  tr_cs[c] = sram_cs_n; tr_oe[c] = sram_oe_n;
    tr_we[c] = sram_we_n; tr_doe[c] = sram_doe; tr_pad[c] = sram_dout;
    if (c == 2) tr_addr = sram_addr;
    for (int g = 0; g < 3; g++)
      if (sw_ack[g] && sw_first[g] < 0) sw_first[g] = c;
  endtask

  // present a request in cycle 0; at drop_at, release cs and scramble the inputs
  task automatic run(input logic w, input logic [15:0] a, input logic [7:0] d,
                     input logic [1:0] b, input int drop_at, input logic [15:0] alt);
    for (int g = 0; g < 3; g++) sw_first[g] = -1;
    @(negedge clk);
    cs = 1'b1; we = w; addr = a; dat_w = d; bank = b;
    for (int c = 0; c < 24; c++) begin
      if (c == drop_at) begin cs = 1'b0; addr = alt; dat_w = ~d; we = ~w; end
      trace_step(c);
      @(negedge clk);
    end
    cs = 1'b0;
  endtask

  initial begin
    logic ack_seen;
    rst_n = 1'b0; mem_init = 1'b1;
    cs = 1'b0; we = 1'b0; addr = '0; dat_w = '0; bank = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1; mem_init = 1'b0;
    @(negedge clk);
    chk("rst_ack", ack, 0);         chk("rst_busy", busy, 0);
    chk("rst_dat", dat_r, 0);       chk("rst_cs_n", sram_cs_n, 1);
    chk("rst_oe_n", sram_oe_n, 1);  chk("rst_we_n", sram_we_n, 1);
    chk("rst_doe", sram_doe, 0);    chk("rst_addr", sram_addr, 0);
    chk("rst_sdat", sram_dout, 0);

    // read, bank 01
    run(1'b0, 16'h1234, 8'h00, 2'b01, 1, 16'h1234);
    chk("rd_addr", tr_addr, 18'h11234);
    chk("rd_oe_n", tr_oe[5:0], 6'b110011);
    chk("rd_ack", tr_ack, 24'h000010);
    chk("rd_we_n", tr_we, 24'hFFFFFF);
    chk("rd_doe", tr_doe, 24'h0);
    chk("rd_dat", dat_r, 8'hA5);
    for (int g = 0; g < 3; g++) chk($sformatf("sw_rd%0d", SW_RD[g]), sw_first[g], 3 + SW_RD[g]);

    // write, no wait states
    run(1'b1, 16'h8000, 8'h3C, 2'b00, 1, 16'h8000);
    chk("wr_we_n", tr_we[5:0], 6'b111011);
    chk("wr_doe", tr_doe[5:0], 6'b001110);
    chk("wr_pad", {tr_pad[1], tr_pad[2], tr_pad[3]}, 24'h3C3C3C);
    chk("wr_ack", tr_ack, 24'h000008);
    chk("wr_oe_n", tr_oe, 24'hFFFFFF);
    chk("wr_mem", mem[8'h00], 8'h3C);
    chk("wr_keep_dat", dat_r, 8'hA5);
    for (int g = 0; g < 3; g++) chk($sformatf("sw_wr%0d", SW_WR[g]), sw_first[g], 3 + SW_WR[g]);

    // back-to-back: write then read with cs held through the IDLE cycle
    @(negedge clk);
    cs = 1'b1; we = 1'b1; addr = 16'h0010; dat_w = 8'h55; bank = 2'b00;
    for (int c = 0; c < 24; c++) begin
      if (c == 4) we = 1'b0;
      if (c == 5) cs = 1'b0;
      trace_step(c);
      @(negedge clk);
    end
    chk("b2b_ack", tr_ack, 24'h000108);
    chk("b2b_cs_n", tr_cs[9:0], 10'b1000010001);
    chk("b2b_dat", dat_r, 8'h55);

    // inputs change mid-write
    run(1'b1, 16'h0020, 8'h77, 2'b10, 2, 16'h0030);
    chk("drop_addr", tr_addr, 18'h20020);
    chk("drop_mem", mem[8'h20], 8'h77);
    chk("drop_alt", mem[8'h30], 8'h00);
    chk("drop_acks", $countones(tr_ack), 1);

    // reset during the ACCESS cycle of a write
    @(negedge clk);
    cs = 1'b1; we = 1'b1; addr = 16'h0040; dat_w = 8'h99;
    @(negedge clk); cs = 1'b0;
    @(negedge clk);
    chk("rst_mid_access", sram_we_n, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_we_n", sram_we_n, 1); chk("rstmid_cs_n", sram_cs_n, 1);
    chk("rstmid_doe", sram_doe, 0);   chk("rstmid_ack", ack, 0);
    @(negedge clk); rst_n = 1'b1;
    ack_seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      ack_seen |= ack;
      @(negedge clk);
    end
    chk("rstmid_no_ack", ack_seen, 0);
    run(1'b0, 16'h0010, 8'h00, 2'b00, 1, 16'h0010);
    chk("post_rst_ack", tr_ack, 24'h000010);
    chk("post_rst_dat", dat_r, 8'h55);

    chk("bus_mutex", viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
